// File: rtl/imu_rd_seq.sv
// IMU readout sequencer: configures the IMU over an SPI master after power-up, then reads
// pitch rate and Z-accel on each data-ready interrupt and fuses them into a pitch estimate.
//
// state      | meaning
// INIT_WAIT  | power-on settle count
// CFG0..CFG3 | IMU configuration writes
// IDLE       | wait for synchronized INT
// RD_RL..AH  | read rate low/high, accel-Z low/high bytes
// UPDATE     | fuse sample into ptch_int, pulse vld
module imu_rd_seq #(
    parameter int          INIT_WAIT_W    = 16,
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
    parameter int          FUSION_GAIN    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld
);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_CFG0,
        S_CFG1,
        S_CFG2,
        S_CFG3,
        S_IDLE,
        S_RD_RL,
        S_RD_RH,
        S_RD_AL,
        S_RD_AH,
        S_UPDATE
    } state_t;

    localparam logic [INIT_WAIT_W-1:0] CNT_MAX = {INIT_WAIT_W{1'b1}};
    localparam logic [INIT_WAIT_W-1:0] CNT_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    state_t                 xfer_next;
    logic [15:0]            xfer_cmd;
    logic                   pend_q, pend_d;
    logic [INIT_WAIT_W-1:0] cnt_q, cnt_d;
    logic                   int_meta_q, int_sync_q;
    logic [7:0]             rate_l_q, rate_l_d, rate_h_q, rate_h_d;
    logic [7:0]             az_l_q, az_l_d, az_h_q, az_h_d;
    logic [26:0]            ptch_int_q, ptch_int_d;
    logic [15:0]            ptch_q, ptch_d;
    logic [15:0]            ptch_rt_q, ptch_rt_d;
    logic                   vld_q, vld_d;

    logic [15:0]            rate_raw, rt_c, az_c, ptch_acc;
    logic signed [25:0]     prod;
    logic                   acc_gt;
    logic [26:0]            rt_c_ext, fus_gain, fusion, ptch_int_upd;
    logic                   unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    // Fusion datapath; only consumed in UPDATE, where the byte registers are all fresh.
    assign rate_raw     = {rate_h_q, rate_l_q};
    assign rt_c         = rate_raw - PTCH_RT_OFFSET;
    assign az_c         = {az_h_q, az_l_q} - AZ_OFFSET;
    assign prod         = $signed({{10{az_c[15]}}, az_c}) * $signed(26'd327);
    assign ptch_acc     = {{3{prod[25]}}, prod[25:13]};
    assign acc_gt       = $signed(ptch_acc) > $signed(ptch_q);
    assign rt_c_ext     = {{11{rt_c[15]}}, rt_c};
    assign fus_gain     = 27'(FUSION_GAIN);
    assign fusion       = acc_gt ? fus_gain : (27'd0 - fus_gain);
    assign ptch_int_upd = ptch_int_q - rt_c_ext + fusion;

    always_comb begin
        xfer_cmd  = 16'h0000;
        xfer_next = S_INIT_WAIT;
        case (state_q)
            S_CFG0:  begin xfer_cmd = 16'h0D02; xfer_next = S_CFG1;   end
            S_CFG1:  begin xfer_cmd = 16'h1160; xfer_next = S_CFG2;   end
            S_CFG2:  begin xfer_cmd = 16'h1250; xfer_next = S_CFG3;   end
            S_CFG3:  begin xfer_cmd = 16'h1460; xfer_next = S_IDLE;   end
            S_RD_RL: begin xfer_cmd = 16'hA400; xfer_next = S_RD_RH;  end
            S_RD_RH: begin xfer_cmd = 16'hA500; xfer_next = S_RD_AL;  end
            S_RD_AL: begin xfer_cmd = 16'hAC00; xfer_next = S_RD_AH;  end
            S_RD_AH: begin xfer_cmd = 16'hAD00; xfer_next = S_UPDATE; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        rate_l_d   = rate_l_q;
        rate_h_d   = rate_h_q;
        az_l_d     = az_l_q;
        az_h_d     = az_h_q;
        ptch_int_d = ptch_int_q;
        ptch_d     = ptch_q;
        ptch_rt_d  = ptch_rt_q;
        vld_d      = 1'b0;
        wrt        = 1'b0;
        cmd        = 16'h0000;
        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = S_CFG0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_IDLE: begin
                if (int_sync_q) state_d = S_RD_RL;
            end
            S_UPDATE: begin
                ptch_rt_d  = rate_raw;
                ptch_int_d = ptch_int_upd;
                ptch_d     = ptch_int_upd[26:11];
                vld_d      = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                // pend_q low marks the issue cycle, so a done coinciding with wrt is never seen
                cmd = xfer_cmd;
                if (!pend_q) begin
                    wrt    = 1'b1;
                    pend_d = 1'b1;
                end else if (done) begin
                    pend_d  = 1'b0;
                    state_d = xfer_next;
                    case (state_q)
                        S_RD_RL: rate_l_d = rd_data[7:0];
                        S_RD_RH: rate_h_d = rd_data[7:0];
                        S_RD_AL: az_l_d   = rd_data[7:0];
                        S_RD_AH: az_h_d   = rd_data[7:0];
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT_WAIT;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            rate_l_q   <= 8'h00;
            rate_h_q   <= 8'h00;
            az_l_q     <= 8'h00;
            az_h_q     <= 8'h00;
            ptch_int_q <= 27'd0;
            ptch_q     <= 16'h0000;
            ptch_rt_q  <= 16'h0000;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
            rate_l_q   <= rate_l_d;
            rate_h_q   <= rate_h_d;
            az_l_q     <= az_l_d;
            az_h_q     <= az_h_d;
            ptch_int_q <= ptch_int_d;
            ptch_q     <= ptch_d;
            ptch_rt_q  <= ptch_rt_d;
            vld_q      <= vld_d;
        end
    end

    assign ptch    = ptch_q;
    assign ptch_rt = ptch_rt_q;
    assign vld     = vld_q;

endmodule

// File: tb/tb_imu_rd_seq.sv
// Randomized scoreboard bench for imu_rd_seq: an SPI responder supplies read bytes and a
// high-level arithmetic model predicts every ptch/ptch_rt sample; a monitor checks each vld.
module tb_imu_rd_seq;
    localparam longint M27 = 134217728;
    localparam longint H27 = 67108864;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, vld;
    logic [15:0] cmd, ptch, ptch_rt;

    imu_rd_seq #(.INIT_WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .ptch(ptch), .ptch_rt(ptch_rt), .vld(vld)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // responder / model state
    bit          busy = 0, stray_same = 0, inject_done = 0, fixed_mode = 0, seen_al = 0;
    bit          hold_chk = 0, conv_mode = 0, conv_reached = 0, vld_prev = 0;
    int          cnt = 0, cmd_idx = 0, n_wrt = 0, n_vld = 0, lat_lo = 5, lat_hi = 5;
    int          first_wrt_cyc = -1, last_wrt_cyc = -1, last_done_cyc = -1, last_vld_cyc = -1;
    logic [7:0]  fixed_b [4];
    logic [7:0]  rb [4];
    logic [7:0]  cur_byte = 8'h00;
    longint      m_int = 0, m_ptch = 0, conv_last = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    task automatic check(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    endtask

    task automatic timeout(string name);
        n_chk++;
        $display("FAIL timeout %s: condition not reached within cycle budget (cycle %0d)", name, cyc);
    endtask

    function automatic longint sx16(longint v);
        longint t;
        t = v & 64'hFFFF;
        return (t >= 32768) ? t - 65536 : t;
    endfunction

    function automatic logic [15:0] exp_cmd(int idx);
        case (idx)
            0: return 16'h0D02;
            1: return 16'h1160;
            2: return 16'h1250;
            3: return 16'h1460;
            default: case ((idx - 4) % 4)
                0: return 16'hA400;
                1: return 16'hA500;
                2: return 16'hAC00;
                default: return 16'hAD00;
            endcase
        endcase
    endfunction

    // Pitch estimate from the four bytes of one read, in plain integer arithmetic.
    task automatic model_sample();
        longint rate, rt_c, az_c, acc;
        logic [15:0] r16, p16;
        rate = sx16({rb[1], rb[0]});
        rt_c = sx16(rate - 80);
        az_c = sx16(sx16({rb[3], rb[2]}) - 160);
        acc  = (az_c * 327) >>> 13;
        m_int = m_int - rt_c + ((acc > m_ptch) ? 1024 : -1024);
        m_int = m_int & (M27 - 1);
        if (m_int >= H27) m_int = m_int - M27;
        m_ptch = m_int >>> 11;
        r16 = rate[15:0];
        p16 = m_ptch[15:0];
        exp_q.push_back({r16, p16});
    endtask

    // SPI master model and command checker
    always @(negedge clk) begin
        int k;
        done = 1'b0;
        if (!rst_n) begin
            busy = 0; cnt = 0; cmd_idx = 0;
            m_int = 0; m_ptch = 0;
            exp_q.delete();
        end else begin
            if (wrt) begin
                check("wrt_spacing", busy, 0);
                check("cmd_word", cmd, exp_cmd(cmd_idx));
                if (first_wrt_cyc < 0) first_wrt_cyc = cyc;
                if (hold_chk && exp_cmd(cmd_idx) == 16'hA400 && last_vld_cyc >= 0)
                    check("int_hold_gap", cyc - last_vld_cyc, 1);
            end
            if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    done = 1'b1;
                    rd_data = {8'($urandom), cur_byte};
                    busy = 0;
                    last_done_cyc = cyc;
                end
            end else if (inject_done && !wrt) begin
                done = 1'b1;
                rd_data = 16'hFFEE;
                inject_done = 0;
            end
            if (wrt) begin
                n_wrt++;
                last_wrt_cyc = cyc;
                busy = 1;
                cnt = $urandom_range(lat_hi, lat_lo);
                if (cmd_idx >= 4) begin
                    k = (cmd_idx - 4) % 4;
                    cur_byte = fixed_mode ? fixed_b[k] : 8'($urandom_range(255, 0));
                    rb[k] = cur_byte;
                    if (k == 2) seen_al = 1;
                    if (k == 3) model_sample();
                end else begin
                    cur_byte = 8'($urandom);
                end
                cmd_idx++;
                if (stray_same) begin
                    done = 1'b1;
                    rd_data = {8'h5A, ~cur_byte};
                end
            end
        end
    end

    // vld monitor / scoreboard
    always @(negedge clk) begin
        longint p;
        if (!rst_n) begin
            vld_prev = 0;
        end else begin
            if (vld) begin
                check("vld_width", vld_prev, 0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL vld_unexpected: got vld=1 with no sample outstanding, required none at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ptch_rt", ptch_rt, e[31:16]);
                    check("ptch", ptch, e[15:0]);
                end
                n_vld++;
                last_vld_cyc = cyc;
                if (conv_mode) begin
                    p = longint'($signed(ptch));
                    if (!conv_reached) begin
                        check("conv_monotonic", (p >= conv_last) ? 1 : 0, 1);
                        if (p >= 326) conv_reached = 1;
                    end else begin
                        check("conv_hold", (p >= 326 && p <= 328) ? 1 : 0, 1);
                    end
                    conv_last = p;
                end
            end
            vld_prev = vld;
        end
    end

    task automatic wait_wrt(int target, int bound, string name);
        int k = 0;
        while (n_wrt < target && k < bound) begin @(negedge clk); k++; end
        if (n_wrt < target) timeout(name);
    endtask

    task automatic wait_vld(int target, int bound, string name);
        int k = 0;
        while (n_vld < target && k < bound) begin @(negedge clk); k++; end
        if (n_vld < target) timeout(name);
    endtask

    task automatic drain(int bound, string name);
        int k = 0;
        repeat (5) @(negedge clk);
        while ((busy || exp_q.size() != 0) && k < bound) begin @(negedge clk); k++; end
        if (busy || exp_q.size() != 0) timeout(name);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_wrt"}, wrt, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_ptch"}, ptch, 0);
        check({tag, "_ptch_rt"}, ptch_rt, 0);
        check({tag, "_vld"}, vld, 0);
    endtask

    initial begin
        int rel, int_cyc, w0, v0, k;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // power-on config
        rst_n = 1'b1;
        rel = cyc;
        wait_wrt(1, 100, "first_wrt");
        check("init_wait_len", first_wrt_cyc - rel, 16);
        wait_wrt(4, 200, "config_writes");
        drain(100, "config_drain");
        repeat (50) @(negedge clk);
        check("no_read_int_low", n_wrt, 4);

        // single directed read
        fixed_mode = 1;
        fixed_b = '{8'h50, 8'h01, 8'hA0, 8'h00};
        INT = 1'b1;
        int_cyc = cyc;
        wait_wrt(5, 20, "int_to_wrt");
        INT = 1'b0;
        check("int_to_wrt_latency", last_wrt_cyc - int_cyc, 3);
        wait_vld(1, 200, "single_vld");
        drain(100, "single_drain");
        check("single_ptch_rt", ptch_rt, 16'h0150);
        check("single_ptch", ptch, 16'hFFFF);
        check("done_to_vld_latency", last_vld_cyc - last_done_cyc, 2);
        repeat (20) @(negedge clk);
        check("single_vld_count", n_vld, 1);

        // stray done while idle
        w0 = n_wrt; v0 = n_vld;
        inject_done = 1;
        repeat (20) @(negedge clk);
        check("stray_idle_wrt", n_wrt, w0);
        check("stray_idle_vld", n_vld, v0);

        // stray done coincident with every wrt, random bytes
        fixed_mode = 0;
        stray_same = 1;
        lat_lo = 2; lat_hi = 4;
        INT = 1'b1;
        wait_wrt(w0 + 1, 20, "stray_same_start");
        INT = 1'b0;
        wait_vld(v0 + 1, 200, "stray_same_vld");
        drain(100, "stray_same_drain");
        stray_same = 0;

        // INT held high: back-to-back random reads
        lat_lo = 1; lat_hi = 3;
        last_vld_cyc = -1;
        hold_chk = 1;
        v0 = n_vld;
        INT = 1'b1;
        wait_vld(v0 + 25, 3000, "int_hold_vld");
        INT = 1'b0;
        drain(200, "int_hold_drain");
        hold_chk = 0;

        // reset in the middle of a read, after the RD_AL wrt
        lat_lo = 3; lat_hi = 3;
        seen_al = 0;
        INT = 1'b1;
        k = 0;
        while (!seen_al && k < 200) begin @(negedge clk); k++; end
        if (!seen_al) timeout("reach_rd_al");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midread_rst");
        fixed_mode = 1;
        fixed_b = '{8'h50, 8'h00, 8'hA0, 8'h20};
        lat_lo = 1; lat_hi = 1;
        first_wrt_cyc = -1;
        repeat (2) @(negedge clk);
        w0 = n_wrt;
        v0 = n_vld;
        conv_mode = 1;
        rst_n = 1'b1;
        rel = cyc;
        wait_wrt(w0 + 1, 100, "rerun_first_wrt");
        check("rerun_init_wait_len", first_wrt_cyc - rel, 16);

        // fusion convergence toward ptch_acc = 327
        wait_vld(v0 + 2000, 40000, "conv_samples");
        INT = 1'b0;
        drain(200, "conv_drain");
        conv_mode = 0;
        check("conv_reached", conv_reached, 1);
        check("conv_final", ($signed(ptch) >= 326 && $signed(ptch) <= 328) ? 1 : 0, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
